mem_arbiter: RTL and testbench

Two-master, one-slave memory arbiter for the NPC core: shares a single valid/ready memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Arbitrates round-robin, registers the winning request, issues it downstream, waits for the response (with timeout), and returns it to the owner. One transaction is outstanding at a time. Sits between the core front-end/LSU and the memory/bus bridge that wraps `npc_pmem_read`/`npc_pmem_write`.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Round-robin IFU/LSU arbiter onto one valid/ready memory port
// One transaction outstanding; a timed-out response is completed with err and the late reply dropped.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_err,
  output logic                busy,
  output logic                owner
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_RSP     = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  logic [1:0]          state;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt;
  logic                drop_pending;
  logic                owner_q;
  logic                last_grant;
  logic                idle_free;
  logic                grant_ifu;
  logic                grant_lsu;
  logic                timed_out;

  // req_ready is combinational on req_valid, so it is also forced low while reset is held
  assign idle_free = (state == S_IDLE) && !drop_pending && !reset;
  assign grant_ifu = idle_free && ifu_req_valid && (!lsu_req_valid || last_grant);
  assign grant_lsu = idle_free && lsu_req_valid && (!ifu_req_valid || !last_grant);
  assign timed_out = (TIMEOUT != 0) && (cnt == TIMEOUT_CNT);

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign mem_rsp_ready = (state == S_RSP) || drop_pending;
  assign ifu_rsp_valid = (state == S_DELIVER) && !owner_q;
  assign lsu_rsp_valid = (state == S_DELIVER) && owner_q;
  assign ifu_rsp_data  = rdata_q;
  assign lsu_rsp_data  = rdata_q;
  assign ifu_rsp_err   = err_q;
  assign lsu_rsp_err   = err_q;
  assign busy          = (state != S_IDLE) || drop_pending;
  assign owner         = owner_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt          <= '0;
      drop_pending <= 1'b0;
      owner_q      <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      // The stale reply after a timeout is swallowed here, whatever state we are in
      if (drop_pending && mem_rsp_valid) drop_pending <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_ifu || grant_lsu) begin
            owner_q    <= grant_lsu;
            last_grant <= grant_lsu;
            addr_q     <= grant_lsu ? lsu_req_addr : ifu_req_addr;
            wen_q      <= grant_lsu && lsu_req_wen;
            wdata_q    <= grant_lsu ? lsu_req_wdata : '0;
            wmask_q    <= grant_lsu ? lsu_req_wmask : '0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= S_RSP;
          end
        end
        S_RSP: begin
          if (mem_rsp_valid) begin
            rdata_q <= mem_rsp_data;
            err_q   <= mem_rsp_err;
            state   <= S_DELIVER;
          end else if (timed_out) begin
            rdata_q      <= '0;
            err_q        <= 1'b1;
            drop_pending <= 1'b1;
            state        <= S_DELIVER;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DELIVER: begin
          if (owner_q ? lsu_rsp_ready : ifu_rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Self-checking bench for mem_arbiter
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [AW-1:0] ifu_req_addr;
  logic [DW-1:0] ifu_rsp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_rsp_data;
  logic [MW-1:0] lsu_req_wmask;
  logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_rsp_data;
  logic [MW-1:0] mem_req_wmask;
  logic          busy, owner;

  int checks = 0;
  int failures = 0;
  // Reference round-robin memory: 1 when the last grant went to the LSU
  logic model_last_lsu;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
    .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
    .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err),
    .busy(busy), .owner(owner)
  );

  task automatic test_reset();
    reset = 1'b1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_req_addr = 32'h1234; lsu_req_addr = 32'h5678; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hffff_ffff; lsu_req_wmask = 4'hf;
    ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_rsp_ready, busy, owner} !== 8'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000000", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_rsp_ready, busy, owner});
    end
    checks++;
    if ({mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, ifu_rsp_data, ifu_rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wdata=%h mask=%h rdata=%h want all 0", mem_req_addr, mem_req_wdata, mem_req_wmask, ifu_rsp_data);
    end
    @(negedge clk);
    reset = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    #1;
    checks++;
    if ({busy, owner, mem_req_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release got=%b want=000", {busy, owner, mem_req_valid});
    end
    model_last_lsu = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic exp_lsu;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000 + AW'(t * 4);
      lsu_req_valid = 1'b1; lsu_req_addr = 32'h9000_0000 + AW'(t * 4); lsu_req_wen = 1'b0;
      exp_lsu = ~model_last_lsu;
      #1;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
        failures++;
        $display("FAIL b2b_grant t=%0d got=%b want=%b", t, {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu});
      end
      @(negedge clk); mem_req_ready = 1'b1; #1;
      checks++;
      if (mem_req_valid !== 1'b1 || owner !== exp_lsu || mem_req_addr !== (exp_lsu ? lsu_req_addr : ifu_req_addr)) begin
        failures++;
        $display("FAIL b2b_req t=%0d got valid=%b owner=%b addr=%h want owner=%b", t, mem_req_valid, owner, mem_req_addr, exp_lsu);
      end
      @(negedge clk); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = DW'(t * 3 + 1); #1;
      @(negedge clk); mem_rsp_valid = 1'b0; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1; #1;
      checks++;
      if ({ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu, 2'b00} || ifu_rsp_data !== DW'(t * 3 + 1)) begin
        failures++;
        $display("FAIL b2b_rsp t=%0d got=%b data=%h want=%b data=%h", t, {ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready}, ifu_rsp_data, {~exp_lsu, exp_lsu, 2'b00}, DW'(t * 3 + 1));
      end
      model_last_lsu = exp_lsu;
    end
    @(negedge clk);
    ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
  endtask

  task automatic test_ifu_single();
    @(negedge clk); ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b100) begin
      failures++;
      $display("FAIL ifu_accept got=%b want=100", {ifu_req_ready, lsu_req_ready, mem_req_valid});
    end
    @(negedge clk); ifu_req_valid = 1'b0; ifu_req_addr = 32'h0; mem_req_ready = 1'b1; #1;
    checks++;
    if ({mem_req_valid, mem_req_wen} !== 2'b10 || mem_req_addr !== 32'h8000_0000 || mem_req_wdata !== '0 || mem_req_wmask !== '0) begin
      failures++;
      $display("FAIL ifu_req got valid=%b wen=%b addr=%h wdata=%h mask=%h want 1 0 80000000 0 0", mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask);
    end
    @(negedge clk); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413; mem_rsp_err = 1'b0; #1;
    checks++;
    if ({mem_rsp_ready, mem_req_valid, ifu_rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL ifu_rsp_wait got=%b want=100", {mem_rsp_ready, mem_req_valid, ifu_rsp_valid});
    end
    @(negedge clk); mem_rsp_valid = 1'b0; ifu_rsp_ready = 1'b1; #1;
    checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, owner} !== 4'b1000 || ifu_rsp_data !== 32'h0000_0413) begin
      failures++;
      $display("FAIL ifu_deliver got=%b data=%h want=1000 data=00000413", {ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, owner}, ifu_rsp_data);
    end
    @(negedge clk); ifu_rsp_ready = 1'b0; #1;
    checks++;
    if ({ifu_rsp_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL ifu_done got=%b want=00", {ifu_rsp_valid, busy});
    end
    model_last_lsu = 1'b0;
  endtask

  task automatic test_store_stall();
    logic [31:0] d;
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hdead_beef; lsu_req_wmask = 4'h3;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL store_accept got=%b want=01", {ifu_req_ready, lsu_req_ready});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lsu_req_valid = 1'b0; lsu_req_addr = $urandom; lsu_req_wdata = $urandom; lsu_req_wmask = 4'($urandom);
      mem_req_ready = (i == 3);
      #1;
      checks++;
      if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask} !== {2'b11, 32'h8000_1000, 32'hdead_beef, 4'h3}) begin
        failures++;
        $display("FAIL store_req_stable i=%0d got v=%b wen=%b addr=%h wdata=%h mask=%h", i, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask);
      end
    end
    d = $urandom;
    @(negedge clk); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = d; #1;
    checks++;
    if ({mem_req_valid, mem_rsp_ready} !== 2'b01) begin
      failures++;
      $display("FAIL store_rsp_wait got=%b want=01", {mem_req_valid, mem_rsp_ready});
    end
    @(negedge clk); mem_rsp_valid = 1'b0; lsu_rsp_ready = 1'b1; #1;
    checks++;
    if ({lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_err} !== 3'b100 || lsu_rsp_data !== d) begin
      failures++;
      $display("FAIL store_deliver got=%b data=%h want=100 data=%h", {lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_err}, lsu_rsp_data, d);
    end
    @(negedge clk); lsu_rsp_ready = 1'b0; #1;
    checks++;
    if ({lsu_rsp_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL store_once got=%b want=00", {lsu_rsp_valid, busy});
    end
    model_last_lsu = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [31:0] d, e;
    d = $urandom; e = $urandom;
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 1'b0;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL bp_tie got=%b want=10", {ifu_req_ready, lsu_req_ready});
    end
    @(negedge clk); ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = d;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b0; mem_rsp_data = $urandom; ifu_rsp_ready = (i == 5);
      #1;
      checks++;
      if ({ifu_rsp_valid, lsu_rsp_valid, lsu_req_ready, ifu_req_ready} !== 4'b1000 || ifu_rsp_data !== d) begin
        failures++;
        $display("FAIL bp_hold i=%0d got=%b data=%h want=1000 data=%h", i, {ifu_rsp_valid, lsu_rsp_valid, lsu_req_ready, ifu_req_ready}, ifu_rsp_data, d);
      end
    end
    @(negedge clk); ifu_rsp_ready = 1'b0; #1;
    checks++;
    if ({lsu_req_ready, ifu_rsp_valid, owner} !== 3'b100) begin
      failures++;
      $display("FAIL bp_next_grant got=%b want=100", {lsu_req_ready, ifu_rsp_valid, owner});
    end
    @(negedge clk); lsu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_2000 || owner !== 1'b1) begin
      failures++;
      $display("FAIL bp_lsu_req got v=%b addr=%h owner=%b want 1 80002000 1", mem_req_valid, mem_req_addr, owner);
    end
    @(negedge clk); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rsp_data = e;
    @(negedge clk); mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; lsu_rsp_ready = 1'b1; #1;
    checks++;
    if ({lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid} !== 3'b110 || lsu_rsp_data !== e) begin
      failures++;
      $display("FAIL bp_lsu_rsp got=%b data=%h want=110 data=%h", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid}, lsu_rsp_data, e);
    end
    @(negedge clk); lsu_rsp_ready = 1'b0;
    model_last_lsu = 1'b1;
  endtask

  task automatic test_timeout();
    logic [31:0] f;
    f = $urandom;
    @(negedge clk); ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0100;
    @(negedge clk); ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    for (int i = 0; i <= TO; i++) begin
      @(negedge clk); mem_req_ready = 1'b0; #1;
      checks++;
      if ({mem_rsp_ready, ifu_rsp_valid, busy} !== 3'b101) begin
        failures++;
        $display("FAIL to_wait i=%0d got=%b want=101", i, {mem_rsp_ready, ifu_rsp_valid, busy});
      end
    end
    @(negedge clk); lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1'b0; ifu_rsp_ready = 1'b1; #1;
    checks++;
    if ({ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready, lsu_req_ready} !== 4'b1110 || ifu_rsp_data !== '0) begin
      failures++;
      $display("FAIL to_err got=%b data=%h want=1110 data=0", {ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready, lsu_req_ready}, ifu_rsp_data);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ifu_rsp_ready = 1'b0; mem_rsp_valid = (i == 3); mem_rsp_data = $urandom; #1;
      checks++;
      if ({busy, mem_rsp_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid} !== 5'b11000) begin
        failures++;
        $display("FAIL to_drop_hold i=%0d got=%b want=11000", i, {busy, mem_rsp_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid});
      end
    end
    @(negedge clk); mem_rsp_valid = 1'b0; #1;
    checks++;
    if ({lsu_req_ready, busy, mem_rsp_ready} !== 3'b100) begin
      failures++;
      $display("FAIL to_after_drop got=%b want=100", {lsu_req_ready, busy, mem_rsp_ready});
    end
    @(negedge clk); lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = f;
    @(negedge clk); mem_rsp_valid = 1'b0; lsu_rsp_ready = 1'b1; #1;
    checks++;
    if ({lsu_rsp_valid, lsu_rsp_err} !== 2'b10 || lsu_rsp_data !== f) begin
      failures++;
      $display("FAIL to_next_txn got=%b data=%h want=10 data=%h", {lsu_rsp_valid, lsu_rsp_err}, lsu_rsp_data, f);
    end
    @(negedge clk); lsu_rsp_ready = 1'b0;
    model_last_lsu = 1'b1;
  endtask

  // Expected cycle timeline: grant, 1+d1 request cycles, 1+d2 response-wait cycles, 1+d3 deliver cycles
  task automatic test_random();
    logic        exp_lsu, e_wen, rerr;
    logic [31:0] e_addr, e_wdata, rdata;
    logic [3:0]  e_wmask;
    int          d1, d2, d3;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
      if (!ifu_req_valid && $urandom_range(0, 1) == 1) begin
        ifu_req_valid = 1'b1; ifu_req_addr = $urandom;
      end
      if (!lsu_req_valid && $urandom_range(0, 1) == 1) begin
        lsu_req_valid = 1'b1; lsu_req_addr = $urandom; lsu_req_wen = 1'($urandom);
        lsu_req_wdata = $urandom; lsu_req_wmask = 4'($urandom);
      end
      if (!ifu_req_valid && !lsu_req_valid) begin
        ifu_req_valid = 1'b1; ifu_req_addr = $urandom;
      end
      exp_lsu = lsu_req_valid && (!ifu_req_valid || !model_last_lsu);
      e_addr  = exp_lsu ? lsu_req_addr : ifu_req_addr;
      e_wen   = exp_lsu && lsu_req_wen;
      e_wdata = exp_lsu ? lsu_req_wdata : '0;
      e_wmask = exp_lsu ? lsu_req_wmask : '0;
      d1 = int'($urandom_range(0, 3)); d2 = int'($urandom_range(0, 3)); d3 = int'($urandom_range(0, 3));
      rdata = $urandom; rerr = 1'($urandom);
      #1;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
        failures++;
        $display("FAIL rnd_grant t=%0d got=%b want=%b", t, {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu});
      end
      model_last_lsu = exp_lsu;
      for (int i = 0; i <= d1; i++) begin
        @(negedge clk);
        if (exp_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        mem_req_ready = (i == d1);
        #1;
        checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, owner, busy} !== {1'b1, e_addr, e_wen, e_wdata, e_wmask, exp_lsu, 1'b1}) begin
          failures++;
          $display("FAIL rnd_req t=%0d got v=%b addr=%h wen=%b wdata=%h mask=%h owner=%b want addr=%h wen=%b wdata=%h mask=%h owner=%b",
                   t, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, owner, e_addr, e_wen, e_wdata, e_wmask, exp_lsu);
        end
      end
      for (int j = 0; j <= d2; j++) begin
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = (j == d2);
        mem_rsp_data = (j == d2) ? rdata : $urandom; mem_rsp_err = (j == d2) ? rerr : 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 4'b0100) begin
          failures++;
          $display("FAIL rnd_wait t=%0d got=%b want=0100", t, {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid});
        end
      end
      for (int k = 0; k <= d3; k++) begin
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = $urandom;
        if (exp_lsu) lsu_rsp_ready = (k == d3); else ifu_rsp_ready = (k == d3);
        #1;
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready, mem_rsp_ready} !== {~exp_lsu, exp_lsu, 3'b000} ||
            (exp_lsu ? {lsu_rsp_data, lsu_rsp_err} : {ifu_rsp_data, ifu_rsp_err}) !== {rdata, rerr}) begin
          failures++;
          $display("FAIL rnd_deliver t=%0d got=%b ifu=%h/%b lsu=%h/%b want=%b data=%h err=%b", t,
                   {ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready, mem_rsp_ready}, ifu_rsp_data, ifu_rsp_err,
                   lsu_rsp_data, lsu_rsp_err, {~exp_lsu, exp_lsu, 3'b000}, rdata, rerr);
        end
      end
    end
    @(negedge clk);
    ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic exp_lsu;
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0200;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_4000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'h5555_aaaa; lsu_req_wmask = 4'hf;
    exp_lsu = ~model_last_lsu;
    @(negedge clk); #1;
    checks++;
    if (mem_req_valid !== 1'b1 || owner !== exp_lsu) begin
      failures++;
      $display("FAIL mid_req got v=%b owner=%b want 1 %b", mem_req_valid, owner, exp_lsu);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_rsp_ready, busy, owner} !== 8'b0 ||
        {mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen} !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%b addr=%h wdata=%h want all 0", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_rsp_ready, busy, owner}, mem_req_addr, mem_req_wdata);
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL mid_first_tie got=%b want=10", {ifu_req_ready, lsu_req_ready});
    end
    @(negedge clk); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_ifu_single();
    test_store_stall();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
